// File: rtl/x2050mpx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : x2050mpx_pkg
// Description : Shared types and constants for the multiplexor-channel
//               request-in poller. Holds the poll FSM state encoding, the
//               interrupt-buffer entry width and the status-byte bit names.
//               Status bits use S/360 bus numbering: bus bit 0 is the MSB of
//               the byte, so vector index = 7 - bus bit.
// Revision    : 1.0  initial release
// ============================================================================
package x2050mpx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SELECT    = 2'd1,
        ST_WAIT_ADDR = 2'd2,
        ST_HELD      = 2'd3
    } poll_state_t;

    // Status-byte bit positions, bus-bit numbering (0 = MSB of the byte).
    localparam int ATTN   = 0;
    localparam int SMOD   = 1;
    localparam int CUEND  = 2;
    localparam int BUSY   = 3;
    localparam int CHEND  = 4;
    localparam int DEVEND = 5;
    localparam int UCK    = 6;
    localparam int UEX    = 7;

    // Interrupt-buffer entry: {unit address, status byte}.
    localparam int IB_ENTRY_W = 16;

    // Convert a bus-bit number to a vector index into a [7:0] byte.
    function automatic int stat_idx(input int bus_bit);
        return 7 - bus_bit;
    endfunction

endpackage : x2050mpx_pkg
`default_nettype wire

// File: rtl/x2050mpxibq.sv
`default_nettype none
// ============================================================================
// Module      : x2050mpxibq
// Description : Interrupt-buffer FIFO built from flops, show-ahead head.
//               Push when full is dropped and flagged; push+pop when full
//               performs both; pop when empty is ignored.
// Ports       : i_clk, i_reset (sync, active-low)
//               i_push, i_pop, i_data  - write / read-advance / write data
//               o_data                 - head entry, zero when empty
//               o_count, o_full, o_empty
//               o_ovf                  - one-cycle pulse on a dropped push
// Revision    : 1.0  initial release
// ============================================================================
import x2050mpx_pkg::*;

module x2050mpxibq #(
    parameter int DEPTH = 4,
    parameter int WIDTH = IB_ENTRY_W
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == C_FULL);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A full buffer can still accept a write when the head leaves the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= i_push && !w_do_push;
            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_ovf   = r_ovf;

endmodule : x2050mpxibq
`default_nettype wire

// File: rtl/x2050mpxpoll.sv
`default_nettype none
// ============================================================================
// Module      : x2050mpxpoll
// Description : Multiplexor-channel request-in poller with round-robin
//               select-out grant, address-in capture with odd-parity check,
//               select-out timeout, and an interrupt buffer of
//               {unit address, status}.
// Ports       : i_clk, i_reset (sync, active-low)
//               i_poll_control   - microprogram permits new polls
//               i_request_in     - per-line request-in
//               i_address_in     - device drives unit address on i_bus_in
//               i_bus_in         - [8]=P, [7:0]=bus bits 0..7
//               i_resume_polling - release the held device
//               i_ib_push/pop    - interrupt-buffer write / read-advance
//               i_ib_status      - status byte queued with o_poll_ua
//               o_select_out     - one-hot grant
//               o_request_a0     - one-cycle ROAR request
//               o_poll_ua        - latched unit address
//               o_log            - one-cycle error pulse (timeout / parity)
//               o_ibfull, o_ib_empty, o_ib_count, o_ib_ovf
//               o_ib_ua, o_ib_status, o_ib_devend, o_ib_attn - head entry
// Revision    : 1.0  initial release
// ============================================================================
import x2050mpx_pkg::*;

module x2050mpxpoll #(
    parameter int NSUB     = 8,
    parameter int IB_DEPTH = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_poll_control,
    input  logic [NSUB-1:0]             i_request_in,
    input  logic                        i_address_in,
    input  logic [8:0]                  i_bus_in,
    input  logic                        i_resume_polling,
    input  logic                        i_ib_push,
    input  logic                        i_ib_pop,
    input  logic [7:0]                  i_ib_status,
    output logic [NSUB-1:0]             o_select_out,
    output logic                        o_request_a0,
    output logic [7:0]                  o_poll_ua,
    output logic                        o_log,
    output logic                        o_ibfull,
    output logic                        o_ib_empty,
    output logic [$clog2(IB_DEPTH):0]   o_ib_count,
    output logic [7:0]                  o_ib_ua,
    output logic [7:0]                  o_ib_status,
    output logic                        o_ib_devend,
    output logic                        o_ib_attn,
    output logic                        o_ib_ovf
);

    localparam int PW = (NSUB > 1) ? $clog2(NSUB) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

    poll_state_t      r_state;
    logic [PW-1:0]    r_rr_ptr;
    logic [PW-1:0]    r_grant;
    logic [TW-1:0]    r_tmo;
    logic [NSUB-1:0]  r_select;
    logic             r_a0;
    logic             r_log;
    logic [7:0]       r_ua;

    logic             w_found;
    logic [PW-1:0]    w_pick;
    logic             w_par_ok;
    logic [IB_ENTRY_W-1:0] w_head;

    // Successor line, wrapping at NSUB (which need not be a power of two).
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        if (int'(p) == NSUB - 1) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // First requesting line at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NSUB; i++) begin
            if (!w_found && i_request_in[(int'(r_rr_ptr) + i) % NSUB]) begin
                w_found = 1'b1;
                w_pick  = PW'((int'(r_rr_ptr) + i) % NSUB);
            end
        end
    end

    // Odd parity: the nine bus-in bits must hold an odd number of ones.
    assign w_par_ok = ^i_bus_in;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_tmo    <= '0;
            r_select <= '0;
            r_a0     <= 1'b0;
            r_log    <= 1'b0;
            r_ua     <= '0;
        end else begin
            r_a0  <= 1'b0;
            r_log <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    if (i_poll_control && (|i_request_in)) begin
                        r_state <= ST_SELECT;
                    end
                end

                ST_SELECT: begin
                    // The request may have vanished since IDLE; then just go back.
                    if (w_found) begin
                        r_grant  <= w_pick;
                        r_select <= NSUB'(1) << w_pick;
                        r_tmo    <= '0;
                        r_state  <= ST_WAIT_ADDR;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end

                ST_WAIT_ADDR: begin
                    if (i_address_in) begin
                        r_ua <= i_bus_in[7:0];
                        if (w_par_ok) begin
                            r_a0    <= 1'b1;
                            r_state <= ST_HELD;
                        end else begin
                            // Bad address: move past this line so others get a turn.
                            r_log    <= 1'b1;
                            r_select <= '0;
                            r_rr_ptr <= f_next(r_grant);
                            r_state  <= ST_IDLE;
                        end
                    end else if (!i_request_in[r_grant]) begin
                        r_select <= '0;
                        r_rr_ptr <= f_next(r_grant);
                        r_state  <= ST_IDLE;
                    end else if (r_tmo == C_TMO_LAST) begin
                        r_log    <= 1'b1;
                        r_select <= '0;
                        r_rr_ptr <= f_next(r_grant);
                        r_state  <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end

                ST_HELD: begin
                    if (i_resume_polling) begin
                        r_select <= '0;
                        r_rr_ptr <= f_next(r_grant);
                        r_state  <= ST_IDLE;
                    end
                end

                default: begin
                    r_select <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    x2050mpxibq #(
        .DEPTH (IB_DEPTH),
        .WIDTH (IB_ENTRY_W)
    ) u_ibq (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_ib_push),
        .i_pop   (i_ib_pop),
        .i_data  ({r_ua, i_ib_status}),
        .o_data  (w_head),
        .o_count (o_ib_count),
        .o_full  (o_ibfull),
        .o_empty (o_ib_empty),
        .o_ovf   (o_ib_ovf)
    );

    assign o_select_out = r_select;
    assign o_request_a0 = r_a0;
    assign o_poll_ua    = r_ua;
    assign o_log        = r_log;
    assign o_ib_ua      = w_head[15:8];
    assign o_ib_status  = w_head[7:0];
    assign o_ib_devend  = w_head[stat_idx(DEVEND)];
    assign o_ib_attn    = w_head[stat_idx(ATTN)];

endmodule : x2050mpxpoll
`default_nettype wire

// File: tb/tb_x2050mpxpoll.sv
`default_nettype none
// ============================================================================
// Module      : tb_x2050mpxpoll
// Description : Self-checking bench for x2050mpxpoll. Stimulus queues the
//               expected pulse events (a0 / log / ovf); a monitor pops and
//               compares whenever the DUT raises one. Level outputs are
//               compared directly by the stimulus.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_x2050mpxpoll;
    import x2050mpx_pkg::*;

    localparam int NSUB     = 8;
    localparam int IB_DEPTH = 4;
    localparam int TIMEOUT  = 64;

    localparam logic [1:0] K_A0  = 2'd0;
    localparam logic [1:0] K_LOG = 2'd1;
    localparam logic [1:0] K_OVF = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] sel;
        logic [7:0] ua;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        poll_control;
    logic [7:0]  request_in;
    logic        address_in;
    logic [8:0]  bus_in;
    logic        resume_polling;
    logic        ib_push;
    logic        ib_pop;
    logic [7:0]  ib_status_in;
    logic [7:0]  select_out;
    logic        request_a0;
    logic [7:0]  poll_ua;
    logic        log_p;
    logic        ibfull;
    logic        ib_empty;
    logic [2:0]  ib_count;
    logic [7:0]  ib_ua;
    logic [7:0]  ib_status;
    logic        ib_devend;
    logic        ib_attn;
    logic        ib_ovf;

    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] last_ua = 8'h00;

    always #5 clk = ~clk;

    x2050mpxpoll #(
        .NSUB     (NSUB),
        .IB_DEPTH (IB_DEPTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_poll_control   (poll_control),
        .i_request_in     (request_in),
        .i_address_in     (address_in),
        .i_bus_in         (bus_in),
        .i_resume_polling (resume_polling),
        .i_ib_push        (ib_push),
        .i_ib_pop         (ib_pop),
        .i_ib_status      (ib_status_in),
        .o_select_out     (select_out),
        .o_request_a0     (request_a0),
        .o_poll_ua        (poll_ua),
        .o_log            (log_p),
        .o_ibfull         (ibfull),
        .o_ib_empty       (ib_empty),
        .o_ib_count       (ib_count),
        .o_ib_ua          (ib_ua),
        .o_ib_status      (ib_status),
        .o_ib_devend      (ib_devend),
        .o_ib_attn        (ib_attn),
        .o_ib_ovf         (ib_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input logic [1:0] k, input logic [7:0] s, input logic [7:0] u);
        ev_t e;
        e.kind = k;
        e.sel  = s;
        e.ua   = u;
        return e;
    endfunction

    // Monitor: every pulse the DUT raises must match the oldest expectation.
    initial begin
        ev_t        e;
        logic [1:0] k;
        forever begin
            @(posedge clk);
            #1;
            if (request_a0 || log_p || ib_ovf) begin
                k = ib_ovf ? K_OVF : (log_p ? K_LOG : K_A0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: kind %0d sel 0x%0h ua 0x%0h, expected none",
                             k, select_out, poll_ua);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind",   32'(k),          32'(e.kind));
                    chk("event_select", 32'(select_out), 32'(e.sel));
                    chk("event_ua",     32'(poll_ua),    32'(e.ua));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for a grant and compare it.
    task automatic wait_grant(input string name, input logic [7:0] exp_sel);
        for (int i = 0; i < 40; i++) begin
            if (select_out != 8'h00) break;
            @(negedge clk);
        end
        chk(name, 32'(select_out), 32'(exp_sel));
    endtask

    // One cycle of address-in; queues the expected a0 or log pulse.
    task automatic do_address(input logic [8:0] bus, input bit ok, input logic [7:0] sel_now);
        if (ok) exp_q.push_back(mk_ev(K_A0, sel_now, bus[7:0]));
        else    exp_q.push_back(mk_ev(K_LOG, 8'h00, bus[7:0]));
        last_ua    = bus[7:0];
        address_in = 1'b1;
        bus_in     = bus;
        @(negedge clk);
        address_in = 1'b0;
        bus_in     = 9'h000;
    endtask

    task automatic do_resume();
        resume_polling = 1'b1;
        @(negedge clk);
        resume_polling = 1'b0;
        chk("select_after_resume", 32'(select_out), 32'h0);
    endtask

    task automatic ib_op(input bit push, input bit pop, input logic [7:0] st);
        ib_push      = push;
        ib_pop       = pop;
        ib_status_in = st;
        @(negedge clk);
        ib_push      = 1'b0;
        ib_pop       = 1'b0;
    endtask

    task automatic chk_head(input string name, input logic [7:0] ua, input logic [7:0] st, input int cnt);
        chk({name, "_count"},  32'(ib_count),  32'(cnt));
        chk({name, "_ua"},     32'(ib_ua),     32'(ua));
        chk({name, "_status"}, 32'(ib_status), 32'(st));
        chk({name, "_devend"}, 32'(ib_devend), 32'(st[2]));
        chk({name, "_attn"},   32'(ib_attn),   32'(st[7]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n          = 1'b0;
        poll_control   = 1'b0;
        request_in     = 8'h00;
        address_in     = 1'b0;
        bus_in         = 9'h000;
        resume_polling = 1'b0;
        ib_push        = 1'b0;
        ib_pop         = 1'b0;
        ib_status_in   = 8'h00;
        tick(3);

        // Reset state
        chk("rst_select", 32'(select_out), 32'h0);
        chk("rst_a0",     32'(request_a0), 32'h0);
        chk("rst_log",    32'(log_p),      32'h0);
        chk("rst_ua",     32'(poll_ua),    32'h0);
        chk("rst_count",  32'(ib_count),   32'h0);
        chk("rst_empty",  32'(ib_empty),   32'h1);
        chk("rst_full",   32'(ibfull),     32'h0);
        chk("rst_ovf",    32'(ib_ovf),     32'h0);
        rst_n = 1'b1;
        tick(1);

        // Rotation across lines 0 and 7 (rr starts at 0)
        poll_control = 1'b1;
        request_in   = 8'h81;
        wait_grant("rot_grant0", 8'h01);
        do_address(9'h142, 1'b1, 8'h01);
        tick(2);
        do_resume();
        wait_grant("rot_grant7", 8'h80);
        do_address(9'h07F, 1'b1, 8'h80);
        do_resume();
        wait_grant("rot_grant0_again", 8'h01);
        do_address(9'h181, 1'b1, 8'h01);
        do_resume();

        // Parity failure: 0x042 has an even count of ones across nine bits
        wait_grant("par_grant7", 8'h80);
        do_address(9'h042, 1'b0, 8'h80);
        request_in = 8'h00;
        chk("par_fail_select_drop", 32'(select_out), 32'h0);
        tick(3);
        chk("par_fail_idle", 32'(select_out), 32'h0);

        // Parity good, latch unit address
        request_in = 8'h04;
        wait_grant("par_ok_grant2", 8'h04);
        do_address(9'h142, 1'b1, 8'h04);
        tick(1);
        chk("ua_latched",  32'(poll_ua),    32'h42);
        chk("held_select", 32'(select_out), 32'h04);
        do_resume();   // rr -> 3

        // Request-in drops while waiting for address: silent abandon, rr -> 5
        request_in = 8'h10;
        wait_grant("drop_grant4", 8'h10);
        request_in = 8'h00;
        tick(1);
        chk("drop_select", 32'(select_out), 32'h0);
        tick(2);
        request_in = 8'h30;
        wait_grant("after_drop_grant5", 8'h20);
        do_address(9'h001, 1'b1, 8'h20);
        do_resume();   // rr -> 6

        // Poll control blocks new polls only
        request_in   = 8'h00;
        poll_control = 1'b0;
        tick(1);
        request_in = 8'h08;
        tick(10);
        chk("poll_blocked", 32'(select_out), 32'h0);
        poll_control = 1'b1;
        wait_grant("pc_grant3", 8'h08);
        poll_control = 1'b0;
        tick(3);
        chk("pc_no_abort", 32'(select_out), 32'h08);
        do_address(9'h100, 1'b1, 8'h08);
        do_resume();   // rr -> 4

        // Timeout: select-out to log/drop spans TIMEOUT cycles
        request_in   = 8'h02;
        poll_control = 1'b1;
        wait_grant("tmo_grant1", 8'h02);
        exp_q.push_back(mk_ev(K_LOG, 8'h00, last_ua));
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (select_out != 8'h00 && cnt < 200);
        chk("timeout_cycles", 32'(cnt), 32'(TIMEOUT));
        request_in = 8'h06;
        wait_grant("after_tmo_grant2", 8'h04);
        do_address(9'h07F, 1'b1, 8'h04);
        tick(1);

        // Interrupt buffer while line 2 is held (ua 0x7F)
        ib_op(1'b1, 1'b0, 8'h04);
        ib_op(1'b1, 1'b0, 8'h80);
        ib_op(1'b1, 1'b0, 8'h20);
        ib_op(1'b1, 1'b0, 8'h01);
        chk("ib_full_after4", 32'(ibfull), 32'h1);
        exp_q.push_back(mk_ev(K_OVF, 8'h04, 8'h7F));
        ib_op(1'b1, 1'b0, 8'h40);
        chk_head("ib_head04", 8'h7F, 8'h04, 4);
        chk("ib_not_empty", 32'(ib_empty), 32'h0);
        ib_op(1'b0, 1'b1, 8'h00);
        chk_head("ib_head80", 8'h7F, 8'h80, 3);
        ib_op(1'b1, 1'b0, 8'h11);
        chk("ib_full_again", 32'(ibfull), 32'h1);
        ib_op(1'b1, 1'b1, 8'h22);
        chk_head("ib_pushpop_full", 8'h7F, 8'h20, 4);
        ib_op(1'b0, 1'b1, 8'h00);
        chk_head("ib_drain01", 8'h7F, 8'h01, 3);
        ib_op(1'b0, 1'b1, 8'h00);
        chk_head("ib_drain11", 8'h7F, 8'h11, 2);
        ib_op(1'b0, 1'b1, 8'h00);
        chk_head("ib_drain22", 8'h7F, 8'h22, 1);
        ib_op(1'b0, 1'b1, 8'h00);
        chk_head("ib_empty_head", 8'h00, 8'h00, 0);
        chk("ib_empty_flag", 32'(ib_empty), 32'h1);
        ib_op(1'b0, 1'b1, 8'h00);
        chk("ib_pop_empty_count", 32'(ib_count), 32'h0);
        ib_op(1'b1, 1'b1, 8'h33);
        chk_head("ib_pushpop_empty", 8'h7F, 8'h33, 1);
        ib_op(1'b0, 1'b1, 8'h00);

        // Reset while held with two entries queued
        ib_op(1'b1, 1'b0, 8'h55);
        ib_op(1'b1, 1'b0, 8'h66);
        chk("pre_reset_count", 32'(ib_count), 32'h2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_select", 32'(select_out), 32'h0);
        chk("reset_count",  32'(ib_count),   32'h0);
        chk("reset_empty",  32'(ib_empty),   32'h1);
        chk("reset_ua",     32'(poll_ua),    32'h0);
        last_ua = 8'h00;
        rst_n   = 1'b1;
        request_in = 8'h81;
        wait_grant("post_reset_grant0", 8'h01);
        request_in = 8'h00;
        tick(5);
        chk("post_reset_idle", 32'(select_out), 32'h0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_x2050mpxpoll
`default_nettype wire
